shift_sub_divider: RTL
======================

# shift_sub_divider

Sequential restoring (shift-subtract) unsigned integer divider, the inverse companion of the shift-add multiplier in the same arithmetic datapath. Takes a WIDTH-bit dividend and divisor on a start pulse, produces one quotient bit per clock, and asserts `end_op` with quotient and remainder registered and held. Divide-by-zero is flagged, not trapped.

## Interface

- `WIDTH`, 8: operand, quotient and remainder width, ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `dividend`  in  WIDTH  numerator; sampled on the accepting edge.
- `divisor`  in  WIDTH  denominator; sampled on the accepting edge.
- `quotient`  out  WIDTH  result; valid while `end_op`=1.
- `remainder`  out  WIDTH  result; valid while `end_op`=1.
- `busy`  out  1  high in CALC.
- `end_op`  out  1  high in DONE; held until the next accepted start or reset.
- `div_by_zero`  out  1  high in DONE when the divisor was 0.

## Operation

- Reset (`rst`=0, any state, including mid-operation): state IDLE. `quotient`, `remainder`, `busy`, `end_op`, `div_by_zero` and the internal A/Q/M/count registers all clear to 0.
- FSM states: IDLE → CALC → DONE → (start) CALC or DONE.
- Start acceptance: `start`=1 in IDLE or DONE.
  - Clears `end_op` and `div_by_zero`.
  - Loads M←divisor, Q←dividend, A←0 (WIDTH+1 bits), count←0.
- Divisor ≠ 0: state → CALC.
- Divisor = 0: state → DONE directly. quotient←{WIDTH{1}}, remainder←dividend, `div_by_zero`←1.
- CALC iteration, one per clock:
  - {A,Q} ← {A,Q}<<1.
  - T = A − {0,M} (WIDTH+1 bits).
  - If T[WIDTH]=0: A←T, Q[0]←1. Else A unchanged (restore), Q[0]←0.
  - count increments.
  - After iteration WIDTH: state → DONE, quotient←Q, remainder←A[WIDTH−1:0].
- `start` during CALC is ignored; the operand inputs may change freely after acceptance.
- `quotient` and `remainder` change only on entry to DONE or on reset. Between an accepted start and the next DONE they hold their previous values.
- Invariant at DONE (divisor ≠ 0): dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing

- Edge E0 accepts `start`.
  - Divisor ≠ 0: `busy` is high after E0. Iterations happen on E1..E_WIDTH. After E_WIDTH, `busy`=0 and `end_op`=1. Latency is WIDTH cycles (8 by default); the next start may be accepted on E_WIDTH+1.
  - Divisor = 0: `end_op`=1 and `div_by_zero`=1 after E0 (latency 1).
- Back-to-back: `start` held high in DONE is re-accepted on every edge. `end_op` drops for exactly the CALC duration.
- Reset deassertion is asynchronous to `clk`. The first accept is on the first rising edge with `rst`=1.

## Structure

- Package `shift_sub_divider_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t`
  - `localparam int DIV_WIDTH_DEFAULT = 8`
- Sub-module `nbit_subtractor`: combinational (WIDTH+1)-bit A−M with a borrow/sign output, the mirror of the multiplier's adder.
- The top level holds the FSM, the counter ($clog2(WIDTH+1) bits), the A/Q/M registers and the output registers.

## Test plan

- 200 ÷ 7 → after 8 cycles: `end_op`=1, quotient=28, remainder=4, `div_by_zero`=0.
- 255 ÷ 1 → quotient=255, remainder=0; then 255 ÷ 255 back-to-back → quotient=1, remainder=0, with `end_op` low for exactly 8 cycles between the two results.
- 5 ÷ 9 → quotient=0, remainder=5; 0 ÷ 123 → quotient=0, remainder=0.
- 13 ÷ 0 → one cycle later: `end_op`=1, `div_by_zero`=1, quotient=0xFF, remainder=13.
- Start 100 ÷ 3, then pulse `start` with 50 ÷ 5 at cycle 3 → request ignored; result is quotient=33, remainder=1, still at cycle 8.
- Start 100 ÷ 3, assert `rst`=0 at cycle 4 → all outputs 0 immediately, state IDLE. After release, 100 ÷ 3 → quotient=33, remainder=1.

Source files
------------

// File: rtl/shift_sub_divider_pkg.sv
// Shared types and defaults for the shift-subtract divider.
//   div_state_t       : FSM encoding (IDLE, CALC, DONE)
//   DIV_WIDTH_DEFAULT : default operand width
package shift_sub_divider_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/nbit_subtractor.sv
// Combinational W-bit subtractor a_i - b_i with the sign of the result
// exposed separately; the restoring divider uses the sign to decide
// whether a trial subtraction is kept.
//   a_i    : minuend (W bits)
//   b_i    : subtrahend (W bits)
//   diff_o : low W-1 bits of the difference
//   neg_o  : sign bit of the difference (1 = borrow, result negative)
module nbit_subtractor #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-2:0] diff_o,
  output logic         neg_o
);

  logic [W-1:0] full;

  assign full   = a_i - b_i;
  assign diff_o = full[W-2:0];
  assign neg_o  = full[W-1];

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring (shift-subtract) unsigned divider. One quotient bit
// is produced per clock; quotient/remainder are registered and held in DONE.
//   clk         : rising-edge clock
//   rst         : asynchronous active-low reset
//   start       : request, honoured in IDLE or DONE only
//   dividend    : numerator, sampled on the accepting edge
//   divisor     : denominator, sampled on the accepting edge
//   quotient    : result, valid while end_op = 1
//   remainder   : result, valid while end_op = 1
//   busy        : high while iterating
//   end_op      : high in DONE until the next accepted start or reset
//   div_by_zero : high in DONE when the divisor was zero
module shift_sub_divider
  import shift_sub_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             end_op,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       state_q;
  // The partial remainder is always below M after a restore, so its top bit
  // is zero between iterations; only the shifted trial value needs WIDTH+1.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   a_sh_d;
  logic [WIDTH-1:0] q_sh_d;
  logic [WIDTH-1:0] diff_d;
  logic             neg_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] q_d;

  // {A,Q} << 1
  assign a_sh_d = {a_q, q_q[WIDTH-1]};
  assign q_sh_d = {q_q[WIDTH-2:0], 1'b0};

  nbit_subtractor #(
    .W (WIDTH + 1)
  ) u_sub (
    .a_i    (a_sh_d),
    .b_i    ({1'b0, m_q}),
    .diff_o (diff_d),
    .neg_o  (neg_d)
  );

  // Negative trial result: restore (keep shifted A) and shift in a 0.
  always_comb begin
    a_d = neg_d ? a_sh_d[WIDTH-1:0] : diff_d;
    q_d = {q_sh_d[WIDTH-1:1], ~neg_d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      end_op      <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            m_q   <= divisor;
            q_q   <= dividend;
            a_q   <= '0;
            cnt_q <= '0;
            if (divisor == '0) begin
              // Flag rather than trap: saturated quotient, dividend as remainder.
              state_q     <= DONE;
              busy        <= 1'b0;
              end_op      <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
            end else begin
              state_q     <= CALC;
              busy        <= 1'b1;
              end_op      <= 1'b0;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q   <= DONE;
            busy      <= 1'b0;
            end_op    <= 1'b1;
            quotient  <= q_d;
            remainder <= a_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
